// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Out-of-order issue buffer between Dispatch and the ALU for all non-memory
// instructions. It accepts one decoded instruction per cycle. Each operand
// arrives either as a value or as a pending ROB tag. Pending tags are resolved
// by snooping the ALU and LSB common data buses. Every cycle the lowest-index
// ready entry is issued to the ALU. A branch mispredict (clear) flushes every
// entry.
//
// Optional feature macro: RS_WAKEUP_BYPASS_EN
//   defined   - readiness is taken from post-snoop operands, so an entry whose
//               last tag resolves this cycle issues at this edge, and the CDB
//               value is forwarded onto ALU_Vj/ALU_Vk.
//   undefined - readiness is taken from registered tag bits only. A woken
//               entry therefore issues one edge later, which keeps the CDB
//               compare out of the select path.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable; when low, all state and outputs hold
//   clear               mispredict flush (has priority over dispatch/snoop/issue)
//   Dispatch_*          write request plus instruction fields; Type_j/k = 1
//                       means the low ROB_W bits of Value_j/k are a pending tag
//   ALU_CDB_*, LSB_CDB_* result broadcasts (valid, ROB tag, value)
//   RS_full             no free entry (from registered busy bits)
//   RS_free_pos         lowest free index, 0 when full
//   ALU_S, ALU_*        registered issue valid and issued instruction fields
// ---------------------------------------------------------------------------
module reservation_station #(
    parameter int DEPTH  = 16,
    parameter int POS_W  = 4,
    parameter int OP_W   = 6,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,

    input  logic              Dispatch_RS_S,
    input  logic [OP_W-1:0]   Dispatch_Op,
    input  logic [DATA_W-1:0] Dispatch_A,
    input  logic [DATA_W-1:0] Dispatch_pc,
    input  logic [ROB_W-1:0]  Dispatch_Reorder,
    input  logic              Dispatch_Type_j,
    input  logic              Dispatch_Type_k,
    input  logic [DATA_W-1:0] Dispatch_Value_j,
    input  logic [DATA_W-1:0] Dispatch_Value_k,

    input  logic              ALU_CDB_S,
    input  logic [ROB_W-1:0]  ALU_CDB_Reorder,
    input  logic [DATA_W-1:0] ALU_CDB_Value,
    input  logic              LSB_CDB_S,
    input  logic [ROB_W-1:0]  LSB_CDB_Reorder,
    input  logic [DATA_W-1:0] LSB_CDB_Value,

    output logic              RS_full,
    output logic [POS_W-1:0]  RS_free_pos,

    output logic              ALU_S,
    output logic [OP_W-1:0]   ALU_Op,
    output logic [DATA_W-1:0] ALU_Vj,
    output logic [DATA_W-1:0] ALU_Vk,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_pc,
    output logic [ROB_W-1:0]  ALU_Reorder
);

    // Entry storage. Tag bits live in packed vectors so readiness is a
    // simple bitwise expression across all entries.
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_tj;
    logic [DEPTH-1:0]  r_tk;
    logic [OP_W-1:0]   r_op      [DEPTH];
    logic [DATA_W-1:0] r_a       [DEPTH];
    logic [DATA_W-1:0] r_pc      [DEPTH];
    logic [ROB_W-1:0]  r_reorder [DEPTH];
    logic [DATA_W-1:0] r_vj      [DEPTH];
    logic [DATA_W-1:0] r_vk      [DEPTH];

    // Post-snoop view of every stored operand.
    logic [DEPTH-1:0]  w_tj_s;
    logic [DEPTH-1:0]  w_tk_s;
    logic [DATA_W-1:0] w_vj_s    [DEPTH];
    logic [DATA_W-1:0] w_vk_s    [DEPTH];

    // Dispatch operands after same-cycle tag capture.
    logic              w_dtj;
    logic              w_dtk;
    logic [DATA_W-1:0] w_dvj;
    logic [DATA_W-1:0] w_dvk;

    logic [POS_W-1:0]  w_free_pos;
    logic              w_wr_en;
    logic [DEPTH-1:0]  w_ready;
    logic [POS_W-1:0]  w_sel;
    logic              w_any;
    logic [DATA_W-1:0] w_iss_vj;
    logic [DATA_W-1:0] w_iss_vk;
    logic [DEPTH-1:0]  w_busy_nxt;

    // Resolve one operand against both CDBs; returns {T, Value}.
    // The ALU CDB wins if both buses carry the same tag.
    function automatic logic [DATA_W:0] resolve(
        input logic              t,
        input logic [DATA_W-1:0] v,
        input logic              alu_s,
        input logic [ROB_W-1:0]  alu_tag,
        input logic [DATA_W-1:0] alu_val,
        input logic              lsb_s,
        input logic [ROB_W-1:0]  lsb_tag,
        input logic [DATA_W-1:0] lsb_val
    );
        resolve = {t, v};
        if (t) begin
            if (alu_s && (alu_tag == v[ROB_W-1:0])) begin
                resolve = {1'b0, alu_val};
            end else if (lsb_s && (lsb_tag == v[ROB_W-1:0])) begin
                resolve = {1'b0, lsb_val};
            end
        end
    endfunction

    // NOTE: combinational blocks use blocking assignments, and every output
    // gets a value before any condition is tested, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {w_tj_s[i], w_vj_s[i]} = resolve(r_tj[i], r_vj[i],
                                             ALU_CDB_S, ALU_CDB_Reorder, ALU_CDB_Value,
                                             LSB_CDB_S, LSB_CDB_Reorder, LSB_CDB_Value);
            {w_tk_s[i], w_vk_s[i]} = resolve(r_tk[i], r_vk[i],
                                             ALU_CDB_S, ALU_CDB_Reorder, ALU_CDB_Value,
                                             LSB_CDB_S, LSB_CDB_Reorder, LSB_CDB_Value);
        end
    end

    assign {w_dtj, w_dvj} = resolve(Dispatch_Type_j, Dispatch_Value_j,
                                    ALU_CDB_S, ALU_CDB_Reorder, ALU_CDB_Value,
                                    LSB_CDB_S, LSB_CDB_Reorder, LSB_CDB_Value);
    assign {w_dtk, w_dvk} = resolve(Dispatch_Type_k, Dispatch_Value_k,
                                    ALU_CDB_S, ALU_CDB_Reorder, ALU_CDB_Value,
                                    LSB_CDB_S, LSB_CDB_Reorder, LSB_CDB_Value);

    // Lowest free slot: scanning downward lets the lowest index win.
    // When every slot is busy nothing matches and the result stays 0.
    always_comb begin
        w_free_pos = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_pos = POS_W'(i);
            end
        end
    end

    assign RS_full     = &r_busy;
    assign RS_free_pos = w_free_pos;
    // A write while full is dropped here, so it can never touch state.
    assign w_wr_en     = Dispatch_RS_S && !RS_full;

`ifdef RS_WAKEUP_BYPASS_EN
    assign w_ready  = r_busy & ~w_tj_s & ~w_tk_s;
`else
    assign w_ready  = r_busy & ~r_tj & ~r_tk;
`endif

    always_comb begin
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel = POS_W'(i);
            end
        end
    end

    assign w_any = |w_ready;

`ifdef RS_WAKEUP_BYPASS_EN
    assign w_iss_vj = w_vj_s[w_sel];
    assign w_iss_vk = w_vk_s[w_sel];
`else
    assign w_iss_vj = r_vj[w_sel];
    assign w_iss_vk = r_vk[w_sel];
`endif

    // The issued slot is busy and the written slot is free, so the two
    // updates never hit the same bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_any) begin
            w_busy_nxt[w_sel] = 1'b0;
        end
        if (w_wr_en) begin
            w_busy_nxt[w_free_pos] = 1'b1;
        end
    end

    // Control state and issue outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            ALU_S       <= 1'b0;
            ALU_Op      <= '0;
            ALU_Vj      <= '0;
            ALU_Vk      <= '0;
            ALU_A       <= '0;
            ALU_pc      <= '0;
            ALU_Reorder <= '0;
        end else if (rdy) begin
            if (clear) begin
                r_busy <= '0;
                ALU_S  <= 1'b0;
            end else begin
                r_busy <= w_busy_nxt;
                ALU_S  <= w_any;
                if (w_any) begin
                    ALU_Op      <= r_op[w_sel];
                    ALU_Vj      <= w_iss_vj;
                    ALU_Vk      <= w_iss_vk;
                    ALU_A       <= r_a[w_sel];
                    ALU_pc      <= r_pc[w_sel];
                    ALU_Reorder <= r_reorder[w_sel];
                end
            end
        end
    end

    // NOTE: the entry payload is deliberately not reset. Its contents are
    // meaningless while the busy bit is clear, and readiness always
    // qualifies with busy.
    always_ff @(posedge clk) begin
        if (rdy && !clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tj[i] <= w_tj_s[i];
                r_vj[i] <= w_vj_s[i];
                r_tk[i] <= w_tk_s[i];
                r_vk[i] <= w_vk_s[i];
            end
            // A later non-blocking write to the same slot overrides the snoop.
            if (w_wr_en) begin
                r_op[w_free_pos]      <= Dispatch_Op;
                r_a[w_free_pos]       <= Dispatch_A;
                r_pc[w_free_pos]      <= Dispatch_pc;
                r_reorder[w_free_pos] <= Dispatch_Reorder;
                r_tj[w_free_pos]      <= w_dtj;
                r_vj[w_free_pos]      <= w_dvj;
                r_tk[w_free_pos]      <= w_dtk;
                r_vk[w_free_pos]      <= w_dvk;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//
// Directed bench for reservation_station. A behavioural model, kept as an
// array of entry records, predicts every output. A compare process checks the
// DUT against the model on each falling edge. Hand-computed literal checks
// pin the model itself.
// Inputs change 2 time units after the rising edge. Literal checks are made at
// that same point.
// ---------------------------------------------------------------------------
module tb_reservation_station;

    localparam int DEPTH  = 16;
    localparam int POS_W  = 4;
    localparam int OP_W   = 6;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst, rdy, clear;
    logic              Dispatch_RS_S;
    logic [OP_W-1:0]   Dispatch_Op;
    logic [DATA_W-1:0] Dispatch_A, Dispatch_pc;
    logic [ROB_W-1:0]  Dispatch_Reorder;
    logic              Dispatch_Type_j, Dispatch_Type_k;
    logic [DATA_W-1:0] Dispatch_Value_j, Dispatch_Value_k;
    logic              ALU_CDB_S, LSB_CDB_S;
    logic [ROB_W-1:0]  ALU_CDB_Reorder, LSB_CDB_Reorder;
    logic [DATA_W-1:0] ALU_CDB_Value, LSB_CDB_Value;
    logic              RS_full;
    logic [POS_W-1:0]  RS_free_pos;
    logic              ALU_S;
    logic [OP_W-1:0]   ALU_Op;
    logic [DATA_W-1:0] ALU_Vj, ALU_Vk, ALU_A, ALU_pc;
    logic [ROB_W-1:0]  ALU_Reorder;

    reservation_station #(
        .DEPTH(DEPTH), .POS_W(POS_W), .OP_W(OP_W), .ROB_W(ROB_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .Dispatch_RS_S(Dispatch_RS_S), .Dispatch_Op(Dispatch_Op),
        .Dispatch_A(Dispatch_A), .Dispatch_pc(Dispatch_pc),
        .Dispatch_Reorder(Dispatch_Reorder),
        .Dispatch_Type_j(Dispatch_Type_j), .Dispatch_Type_k(Dispatch_Type_k),
        .Dispatch_Value_j(Dispatch_Value_j), .Dispatch_Value_k(Dispatch_Value_k),
        .ALU_CDB_S(ALU_CDB_S), .ALU_CDB_Reorder(ALU_CDB_Reorder), .ALU_CDB_Value(ALU_CDB_Value),
        .LSB_CDB_S(LSB_CDB_S), .LSB_CDB_Reorder(LSB_CDB_Reorder), .LSB_CDB_Value(LSB_CDB_Value),
        .RS_full(RS_full), .RS_free_pos(RS_free_pos),
        .ALU_S(ALU_S), .ALU_Op(ALU_Op), .ALU_Vj(ALU_Vj), .ALU_Vk(ALU_Vk),
        .ALU_A(ALU_A), .ALU_pc(ALU_pc), .ALU_Reorder(ALU_Reorder)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        busy;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic        tj;
        logic [31:0] vj;
        logic        tk;
        logic [31:0] vk;
    } ent_t;

    typedef struct packed {
        logic        s;
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic [31:0] pc;
        logic [3:0]  rob;
    } iss_t;

    ent_t m [DEPTH];
    iss_t e;

    initial begin
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        e = '0;
    end

    // Returns {still_pending, value} for an operand seen against this cycle's CDBs.
    function automatic logic [32:0] wake(input logic t, input logic [31:0] v);
        if (!t) return {1'b0, v};
        if (ALU_CDB_S && ALU_CDB_Reorder == v[3:0]) return {1'b0, ALU_CDB_Value};
        if (LSB_CDB_S && LSB_CDB_Reorder == v[3:0]) return {1'b0, LSB_CDB_Value};
        return {1'b1, v};
    endfunction

    always @(posedge clk) begin : model
        ent_t        nm [DEPTH];
        iss_t        ne;
        int          fp, sel;
        logic [32:0] wj, wk;
        nm = m;
        ne = e;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) nm[i].busy = 1'b0;
            ne = '0;
        end else if (rdy) begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) nm[i].busy = 1'b0;
                ne.s = 1'b0;
            end else begin
                fp = -1;
                for (int i = 0; i < DEPTH; i++) if (fp < 0 && !m[i].busy) fp = i;
                sel = -1;
                for (int i = 0; i < DEPTH; i++) begin
                    wj = wake(m[i].tj, m[i].vj);
                    wk = wake(m[i].tk, m[i].vk);
`ifdef RS_WAKEUP_BYPASS_EN
                    if (sel < 0 && m[i].busy && !wj[32] && !wk[32]) begin
`else
                    if (sel < 0 && m[i].busy && !m[i].tj && !m[i].tk) begin
`endif
                        sel = i;
                        ne = '{s: 1'b1, op: m[i].op, vj: wj[31:0], vk: wk[31:0],
                               a: m[i].a, pc: m[i].pc, rob: m[i].rob};
                    end
                end
                if (sel < 0) ne.s = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    wj = wake(m[i].tj, m[i].vj);
                    wk = wake(m[i].tk, m[i].vk);
                    nm[i].tj = wj[32]; nm[i].vj = wj[31:0];
                    nm[i].tk = wk[32]; nm[i].vk = wk[31:0];
                end
                if (sel >= 0) nm[sel].busy = 1'b0;
                if (Dispatch_RS_S && fp >= 0) begin
                    wj = wake(Dispatch_Type_j, Dispatch_Value_j);
                    wk = wake(Dispatch_Type_k, Dispatch_Value_k);
                    nm[fp] = '{busy: 1'b1, op: Dispatch_Op, a: Dispatch_A, pc: Dispatch_pc,
                               rob: Dispatch_Reorder, tj: wj[32], vj: wj[31:0],
                               tk: wk[32], vk: wk[31:0]};
                end
            end
        end
        m <= nm;
        e <= ne;
    end

    // Compare process: every falling edge once reset has been applied.
    always @(negedge clk) begin : compare
        int cnt, fp;
        if (chk_en) begin
            cnt = 0;
            fp  = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].busy) cnt++;
                else if (fp < 0) fp = i;
            end
            if (fp < 0) fp = 0;
            check("cyc.RS_full",     32'(RS_full),     32'(cnt == DEPTH));
            check("cyc.RS_free_pos", 32'(RS_free_pos), 32'(fp));
            check("cyc.ALU_S",       32'(ALU_S),       32'(e.s));
            check("cyc.ALU_Op",      32'(ALU_Op),      32'(e.op));
            check("cyc.ALU_Vj",      ALU_Vj,           e.vj);
            check("cyc.ALU_Vk",      ALU_Vk,           e.vk);
            check("cyc.ALU_A",       ALU_A,            e.a);
            check("cyc.ALU_pc",      ALU_pc,           e.pc);
            check("cyc.ALU_Reorder", 32'(ALU_Reorder), 32'(e.rob));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] rob,
                        input logic tj, input logic [31:0] vj,
                        input logic tk, input logic [31:0] vk);
        Dispatch_RS_S    = 1'b1;
        Dispatch_Op      = op;
        Dispatch_A       = 32'h1000 + 32'(op);
        Dispatch_pc      = 32'h400 + 32'(rob) * 4;
        Dispatch_Reorder = rob;
        Dispatch_Type_j  = tj;
        Dispatch_Value_j = vj;
        Dispatch_Type_k  = tk;
        Dispatch_Value_k = vk;
        tick();
        Dispatch_RS_S    = 1'b0;
    endtask

    task automatic alu_cdb(input logic s, input logic [3:0] tag, input logic [31:0] val);
        ALU_CDB_S = s; ALU_CDB_Reorder = tag; ALU_CDB_Value = val;
    endtask

    task automatic lsb_cdb(input logic s, input logic [3:0] tag, input logic [31:0] val);
        LSB_CDB_S = s; LSB_CDB_Reorder = tag; LSB_CDB_Value = val;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        Dispatch_RS_S = 1'b0; Dispatch_Op = '0; Dispatch_A = '0; Dispatch_pc = '0;
        Dispatch_Reorder = '0; Dispatch_Type_j = 1'b0; Dispatch_Type_k = 1'b0;
        Dispatch_Value_j = '0; Dispatch_Value_k = '0;
        alu_cdb(1'b0, 4'd0, 32'd0);
        lsb_cdb(1'b0, 4'd0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset.RS_full", 32'(RS_full), 32'd0);
        check("reset.free_pos", 32'(RS_free_pos), 32'd0);
        check("reset.ALU_S", 32'(ALU_S), 32'd0);
        check("reset.ALU_Vj", ALU_Vj, 32'd0);
        check("reset.ALU_Reorder", 32'(ALU_Reorder), 32'd0);

        // Ready ADD issues one edge after the write.
        disp(6'd1, 4'd3, 1'b0, 32'd5, 1'b0, 32'd7);
        check("add.free_pos_after_write", 32'(RS_free_pos), 32'd1);
        check("add.ALU_S_write_edge", 32'(ALU_S), 32'd0);
        tick();
        check("add.ALU_S", 32'(ALU_S), 32'd1);
        check("add.ALU_Vj", ALU_Vj, 32'd5);
        check("add.ALU_Vk", ALU_Vk, 32'd7);
        check("add.ALU_Reorder", 32'(ALU_Reorder), 32'd3);
        check("add.free_pos_back", 32'(RS_free_pos), 32'd0);
        tick();
        check("add.ALU_S_drop", 32'(ALU_S), 32'd0);

        // Tj waits on tag 2; ALU CDB delivers 0x10 two cycles later.
        disp(6'd2, 4'd5, 1'b1, 32'd2, 1'b0, 32'd1);
        tick();
        check("wake.ALU_S_waiting", 32'(ALU_S), 32'd0);
        alu_cdb(1'b1, 4'd2, 32'h10);
        tick();
        alu_cdb(1'b0, 4'd0, 32'd0);
`ifndef RS_WAKEUP_BYPASS_EN
        check("wake.ALU_S_cdb_edge", 32'(ALU_S), 32'd0);
        tick();
`endif
        check("wake.ALU_S", 32'(ALU_S), 32'd1);
        check("wake.ALU_Vj", ALU_Vj, 32'h10);
        check("wake.ALU_Reorder", 32'(ALU_Reorder), 32'd5);
        tick();

        // Fill all 16 slots waiting on tag 9; a 17th write is dropped.
        for (int i = 0; i < DEPTH; i++) disp(6'(i), 4'(i), 1'b1, 32'd9, 1'b0, 32'(i));
        check("fill.RS_full", 32'(RS_full), 32'd1);
        check("fill.free_pos", 32'(RS_free_pos), 32'd0);
        disp(6'h3f, 4'd15, 1'b0, 32'h77, 1'b0, 32'h77);
        check("fill.RS_full_after_17th", 32'(RS_full), 32'd1);
        tick();
        check("fill.17th_not_issued", 32'(ALU_S), 32'd0);
        lsb_cdb(1'b1, 4'd9, 32'h99);
        tick();
        lsb_cdb(1'b0, 4'd0, 32'd0);
`ifndef RS_WAKEUP_BYPASS_EN
        check("fill.ALU_S_cdb_edge", 32'(ALU_S), 32'd0);
        tick();
`endif
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.ALU_S", 32'(ALU_S), 32'd1);
            check("drain.ALU_Reorder", 32'(ALU_Reorder), 32'(i));
            check("drain.ALU_Vj", ALU_Vj, 32'h99);
            check("drain.ALU_Vk", ALU_Vk, 32'(i));
            tick();
        end
        check("drain.ALU_S_end", 32'(ALU_S), 32'd0);
        check("drain.RS_full_end", 32'(RS_full), 32'd0);

        // Tag captured at the write from the LSB CDB.
        lsb_cdb(1'b1, 4'd4, 32'hAB);
        disp(6'd3, 4'd7, 1'b0, 32'd1, 1'b1, 32'd4);
        lsb_cdb(1'b0, 4'd0, 32'd0);
        tick();
        check("capture.ALU_S", 32'(ALU_S), 32'd1);
        check("capture.ALU_Vk", ALU_Vk, 32'hAB);
        check("capture.ALU_Reorder", 32'(ALU_Reorder), 32'd7);
        tick();

        // Five waiting entries, then clear together with a write.
        for (int i = 0; i < 5; i++) disp(6'd4, 4'(i), 1'b1, 32'd12, 1'b0, 32'd0);
        check("flush.free_pos_before", 32'(RS_free_pos), 32'd5);
        clear = 1'b1;
        disp(6'd9, 4'd8, 1'b0, 32'h55, 1'b0, 32'h66);
        clear = 1'b0;
        check("flush.ALU_S", 32'(ALU_S), 32'd0);
        check("flush.free_pos", 32'(RS_free_pos), 32'd0);
        check("flush.RS_full", 32'(RS_full), 32'd0);
        alu_cdb(1'b1, 4'd12, 32'd1);
        tick();
        alu_cdb(1'b0, 4'd0, 32'd0);
        check("flush.no_write", 32'(ALU_S), 32'd0);
        tick();
        check("flush.still_empty", 32'(ALU_S), 32'd0);

        // rdy low holds the issued outputs and the pending entry.
        disp(6'd5, 4'd10, 1'b0, 32'hA, 1'b0, 32'd0);
        disp(6'd5, 4'd11, 1'b0, 32'hB, 1'b0, 32'd0);
        check("hold.first_issue", 32'(ALU_Reorder), 32'd10);
        rdy = 1'b0;
        tick();
        check("hold.ALU_S", 32'(ALU_S), 32'd1);
        check("hold.ALU_Reorder", 32'(ALU_Reorder), 32'd10);
        tick();
        rdy = 1'b1;
        tick();
        check("hold.second_issue", 32'(ALU_Reorder), 32'd11);
        check("hold.second_Vj", ALU_Vj, 32'hB);
        tick();

        // Entries 1 and 3 wake together while 0 and 2 stay pending.
        disp(6'd6, 4'd0, 1'b1, 32'd13, 1'b0, 32'd0);
        disp(6'd6, 4'd1, 1'b1, 32'd14, 1'b0, 32'd0);
        disp(6'd6, 4'd2, 1'b1, 32'd13, 1'b0, 32'd0);
        disp(6'd6, 4'd3, 1'b0, 32'h33, 1'b1, 32'd14);
        alu_cdb(1'b1, 4'd14, 32'h44);
        tick();
        alu_cdb(1'b0, 4'd0, 32'd0);
`ifndef RS_WAKEUP_BYPASS_EN
        check("order.ALU_S_cdb_edge", 32'(ALU_S), 32'd0);
        tick();
`endif
        check("order.first", 32'(ALU_Reorder), 32'd1);
        check("order.first_Vj", ALU_Vj, 32'h44);
        tick();
        check("order.second", 32'(ALU_Reorder), 32'd3);
        check("order.second_Vk", ALU_Vk, 32'h44);
        rst = 1'b1;
        alu_cdb(1'b1, 4'd13, 32'h5);
        tick();
        rst = 1'b0;
        alu_cdb(1'b0, 4'd0, 32'd0);
        check("midrst.ALU_S", 32'(ALU_S), 32'd0);
        check("midrst.ALU_Reorder", 32'(ALU_Reorder), 32'd0);
        check("midrst.free_pos", 32'(RS_free_pos), 32'd0);
        check("midrst.RS_full", 32'(RS_full), 32'd0);
        tick();
        check("midrst.empty", 32'(ALU_S), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
